// File: rtl/wbs_reg_bridge.sv
// wbs_reg_bridge: single-beat Wishbone slave to simple register-bus bridge.
// An in-window access (wbs_adr_i[31:11] == BASE_HI) is forwarded to the
// register bus and completed with wbs_ack_o. An out-of-window access is
// answered with wbs_err_o on the next cycle and never reaches the register bus.
// Optional feature macro: WBS_REG_TIMEOUT_EN bounds the register-bus wait to
// TMO_CYC cycles and answers an expired wait with wbs_err_o.
module wbs_reg_bridge #(
  parameter logic [20:0] BASE_HI = 21'h0,
  parameter logic [15:0] TMO_CYC = 16'd255
) (
  input  logic        app_clk,
  input  logic        reset_ssn,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [31:0] wbs_adr_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        reg_cs,
  output logic        reg_wr,
  output logic [10:0] reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_be,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_cs;
  logic        r_wr;
  logic [10:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_dat;
  logic        r_ack;
  logic        r_err;
  // Set when the master abandons the cycle mid-transaction; the register-bus
  // access still runs to completion but its response is swallowed.
  logic        r_abort;

  logic        w_req;
  logic        w_in_win;
  logic        w_capture;
  logic        w_cs_nxt;
  logic        w_ack_nxt;
  logic        w_err_nxt;
  logic        w_dat_ld;
  logic [31:0] w_dat_nxt;
  logic        w_abort_nxt;
  logic        w_abort_now;

`ifdef WBS_REG_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic        w_tmo_clr;
  logic        w_tmo_inc;
  logic        w_tmo_hit;
`endif

  assign w_req       = wbs_cyc_i & wbs_stb_i;
  assign w_in_win    = (wbs_adr_i[31:11] == BASE_HI);
  assign w_abort_now = r_abort | ~wbs_cyc_i;

`ifdef WBS_REG_TIMEOUT_EN
  // Expiry is taken on the edge that would move the count to TMO_CYC.
  assign w_tmo_hit = (r_tmo_cnt == (TMO_CYC - 16'd1));
`endif

  // State register.
  always_ff @(posedge app_clk or negedge reset_ssn) begin
    if (!reset_ssn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_cs_nxt    = r_cs;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_dat_ld    = 1'b0;
    w_dat_nxt   = '0;
    w_abort_nxt = r_abort;
`ifdef WBS_REG_TIMEOUT_EN
    w_tmo_clr   = 1'b0;
    w_tmo_inc   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_capture   = 1'b1;
          w_abort_nxt = 1'b0;
          if (w_in_win) begin
            w_state_nxt = REQ;
`ifdef WBS_REG_TIMEOUT_EN
            w_tmo_clr   = 1'b1;
`endif
          end else begin
            w_state_nxt = RESP;
            w_err_nxt   = 1'b1;
            w_dat_ld    = 1'b1;
            w_dat_nxt   = '0;
          end
        end
      end
      REQ: begin
        w_state_nxt = WAIT;
        w_cs_nxt    = 1'b1;
        w_abort_nxt = w_abort_now;
      end
      WAIT: begin
        w_abort_nxt = w_abort_now;
        if (reg_ack) begin
          // reg_ack beats a coincident timeout expiry.
          w_state_nxt = RESP;
          w_cs_nxt    = 1'b0;
          w_ack_nxt   = ~w_abort_now;
          w_dat_ld    = 1'b1;
          w_dat_nxt   = r_wr ? 32'h0 : reg_rdata;
`ifdef WBS_REG_TIMEOUT_EN
        end else if (w_tmo_hit) begin
          w_state_nxt = RESP;
          w_cs_nxt    = 1'b0;
          w_err_nxt   = ~w_abort_now;
          w_dat_ld    = 1'b1;
          w_dat_nxt   = '0;
        end else begin
          w_tmo_inc   = 1'b1;
`endif
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Register-bus request fields, captured once per accepted access.
  always_ff @(posedge app_clk or negedge reset_ssn) begin
    if (!reset_ssn) begin
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_be    <= 4'h0;
    end else if (w_capture) begin
      r_addr  <= wbs_adr_i[10:0];
      r_wr    <= wbs_we_i;
      r_wdata <= wbs_dat_i;
      r_be    <= wbs_sel_i;
    end
  end

  // Registered handshake outputs and abort tracking.
  always_ff @(posedge app_clk or negedge reset_ssn) begin
    if (!reset_ssn) begin
      r_cs    <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_cs    <= w_cs_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  // Read data returned to the Wishbone master.
  always_ff @(posedge app_clk or negedge reset_ssn) begin
    if (!reset_ssn) begin
      r_dat <= '0;
    end else if (w_dat_ld) begin
      r_dat <= w_dat_nxt;
    end
  end

`ifdef WBS_REG_TIMEOUT_EN
  // Register-bus wait counter.
  always_ff @(posedge app_clk or negedge reset_ssn) begin
    if (!reset_ssn) begin
      r_tmo_cnt <= '0;
    end else if (w_tmo_clr) begin
      r_tmo_cnt <= '0;
    end else if (w_tmo_inc) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end
`endif

  assign reg_cs    = r_cs;
  assign reg_wr    = r_wr;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_be    = r_be;
  assign wbs_dat_o = r_dat;
  assign wbs_ack_o = r_ack;
  assign wbs_err_o = r_err;

endmodule

// File: tb/tb_wbs_reg_bridge.sv
// tb_wbs_reg_bridge: directed bench for wbs_reg_bridge.
// Inputs are driven and outputs sampled 2 ns after each rising edge; a
// separate monitor counts ack/err/reg_cs cycles on the falling edge.
module tb_wbs_reg_bridge;

  localparam logic [15:0] TMO = 16'd4;

  logic        app_clk = 1'b0;
  logic        reset_ssn;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_we_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic        reg_cs;
  logic        reg_wr;
  logic [10:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_ack;

  int errors = 0;
  int checks = 0;
  int n_ack  = 0;
  int n_err  = 0;
  int n_cs   = 0;
  int n_both = 0;
  int a0, e0, c0;

  always #5 app_clk = ~app_clk;

  wbs_reg_bridge #(
    .BASE_HI(21'h0),
    .TMO_CYC(TMO)
  ) dut (
    .app_clk   (app_clk),
    .reset_ssn (reset_ssn),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_dat_o (wbs_dat_o),
    .wbs_ack_o (wbs_ack_o),
    .wbs_err_o (wbs_err_o),
    .reg_cs    (reg_cs),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_be    (reg_be),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack)
  );

  // Pulse counters, only while out of reset.
  always @(negedge app_clk) begin
    if (reset_ssn) begin
      if (wbs_ack_o) n_ack++;
      if (wbs_err_o) n_err++;
      if (reg_cs) n_cs++;
      if (wbs_ack_o && wbs_err_o) n_both++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge app_clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                       input logic [3:0] sel);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_adr_i = adr;
    wbs_we_i  = we;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
  endtask

  task automatic bus_idle();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_cs"},    {31'h0, reg_cs},    32'h0);
    check({pfx, "_wr"},    {31'h0, reg_wr},    32'h0);
    check({pfx, "_ack"},   {31'h0, wbs_ack_o}, 32'h0);
    check({pfx, "_err"},   {31'h0, wbs_err_o}, 32'h0);
    check({pfx, "_addr"},  {21'h0, reg_addr},  32'h0);
    check({pfx, "_wdata"}, reg_wdata,          32'h0);
    check({pfx, "_be"},    {28'h0, reg_be},    32'h0);
    check({pfx, "_dat"},   wbs_dat_o,          32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ssn = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_adr_i = '0;
    wbs_we_i  = 1'b0;
    wbs_dat_i = '0;
    wbs_sel_i = '0;
    reg_rdata = '0;
    reg_ack   = 1'b0;
    tick();
    tick();
    check_all_zero("rst");
    reset_ssn = 1'b1;
    tick();

    // Write 0x40, reg_ack in the second reg_cs cycle.
    a0 = n_ack; e0 = n_err;
    issue(32'h0000_0040, 1'b1, 32'hA5A5_1234, 4'hF);
    tick();
    check("w_cs_req",  {31'h0, reg_cs}, 32'h0);
    check("w_addr",    {21'h0, reg_addr}, 32'h040);
    check("w_wdata",   reg_wdata, 32'hA5A5_1234);
    check("w_be",      {28'h0, reg_be}, 32'hF);
    check("w_wr",      {31'h0, reg_wr}, 32'h1);
    tick();
    check("w_cs1",     {31'h0, reg_cs}, 32'h1);
    tick();
    check("w_cs2",     {31'h0, reg_cs}, 32'h1);
    reg_ack = 1'b1;
    tick();
    check("w_ack",     {31'h0, wbs_ack_o}, 32'h1);
    check("w_cs_done", {31'h0, reg_cs}, 32'h0);
    check("w_dat",     wbs_dat_o, 32'h0);
    reg_ack = 1'b0;
    bus_idle();
    tick();
    check("w_ack_low", {31'h0, wbs_ack_o}, 32'h0);
    tick();
    check("w_nack",    n_ack - a0, 1);
    check("w_nerr",    n_err - e0, 0);

    // Out-of-window access.
    e0 = n_err; c0 = n_cs;
    issue(32'h0000_0800, 1'b0, 32'h0, 4'hF);
    tick();
    check("oow_err",   {31'h0, wbs_err_o}, 32'h1);
    check("oow_ack",   {31'h0, wbs_ack_o}, 32'h0);
    check("oow_dat",   wbs_dat_o, 32'h0);
    bus_idle();
    tick();
    check("oow_err_lo", {31'h0, wbs_err_o}, 32'h0);
    tick();
    check("oow_nerr",  n_err - e0, 1);
    check("oow_ncs",   n_cs - c0, 0);

    // Read 0x44, reg_ack in the first reg_cs cycle: ack three cycles after request.
    issue(32'h0000_0044, 1'b0, 32'h0, 4'hF);
    reg_rdata = 32'hCAFE_F00D;
    tick();
    check("r_ack_c1",  {31'h0, wbs_ack_o}, 32'h0);
    tick();
    check("r_cs1",     {31'h0, reg_cs}, 32'h1);
    check("r_ack_c2",  {31'h0, wbs_ack_o}, 32'h0);
    reg_ack = 1'b1;
    tick();
    check("r_ack_c3",  {31'h0, wbs_ack_o}, 32'h1);
    check("r_dat",     wbs_dat_o, 32'hCAFE_F00D);
    check("r_addr",    {21'h0, reg_addr}, 32'h044);
    check("r_wr",      {31'h0, reg_wr}, 32'h0);
    reg_ack = 1'b0;
    bus_idle();
    tick();
    check("r_ack_lo",  {31'h0, wbs_ack_o}, 32'h0);

`ifdef WBS_REG_TIMEOUT_EN
    // Timeout after four WAIT cycles, then a stray reg_ack is ignored.
    issue(32'h0000_0048, 1'b0, 32'h0, 4'hF);
    reg_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    check("t_cs1",     {31'h0, reg_cs}, 32'h1);
    tick();
    tick();
    tick();
    check("t_cs4",     {31'h0, reg_cs}, 32'h1);
    check("t_err_pre", {31'h0, wbs_err_o}, 32'h0);
    tick();
    check("t_err",     {31'h0, wbs_err_o}, 32'h1);
    check("t_cs_drop", {31'h0, reg_cs}, 32'h0);
    check("t_dat",     wbs_dat_o, 32'h0);
    bus_idle();
    tick();
    check("t_err_lo",  {31'h0, wbs_err_o}, 32'h0);
    a0 = n_ack; e0 = n_err;
    reg_ack = 1'b1;
    tick();
    tick();
    reg_ack = 1'b0;
    tick();
    check("t_late_ack", n_ack - a0, 0);
    check("t_late_err", n_err - e0, 0);
    check("t_late_cs",  {31'h0, reg_cs}, 32'h0);
    check("t_late_dat", wbs_dat_o, 32'h0);
`else
    // Without the timeout, a long reg-bus stall is waited out.
    issue(32'h0000_0048, 1'b0, 32'h0, 4'hF);
    reg_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    for (int i = 0; i < 20; i++) tick();
    check("s_cs",      {31'h0, reg_cs}, 32'h1);
    check("s_err",     {31'h0, wbs_err_o}, 32'h0);
    check("s_ack_pre", {31'h0, wbs_ack_o}, 32'h0);
    reg_ack = 1'b1;
    tick();
    check("s_ack",     {31'h0, wbs_ack_o}, 32'h1);
    check("s_dat",     wbs_dat_o, 32'hDEAD_BEEF);
    reg_ack = 1'b0;
    bus_idle();
    tick();
`endif

    // Master drops wbs_cyc_i during WAIT: response swallowed.
    a0 = n_ack; e0 = n_err;
    issue(32'h0000_0050, 1'b1, 32'h1111_2222, 4'h3);
    tick();
    tick();
    bus_idle();
    tick();
    check("ab_cs",     {31'h0, reg_cs}, 32'h1);
    reg_ack = 1'b1;
    tick();
    check("ab_ack",    {31'h0, wbs_ack_o}, 32'h0);
    check("ab_err",    {31'h0, wbs_err_o}, 32'h0);
    check("ab_cs_lo",  {31'h0, reg_cs}, 32'h0);
    reg_ack = 1'b0;
    tick();
    tick();
    check("ab_nack",   n_ack - a0, 0);
    check("ab_nerr",   n_err - e0, 0);
    // Following access completes normally.
    issue(32'h0000_0060, 1'b0, 32'h0, 4'hF);
    reg_rdata = 32'h1234_5678;
    tick();
    tick();
    reg_ack = 1'b1;
    tick();
    check("ab_next_ack", {31'h0, wbs_ack_o}, 32'h1);
    check("ab_next_dat", wbs_dat_o, 32'h1234_5678);
    reg_ack = 1'b0;
    bus_idle();
    tick();

    // Reset pulse during WAIT abandons the transaction.
    issue(32'h0000_0070, 1'b1, 32'h5555_AAAA, 4'hC);
    tick();
    tick();
    check("rw_cs",     {31'h0, reg_cs}, 32'h1);
    reset_ssn = 1'b0;
    bus_idle();
    #1;
    check_all_zero("rw");
    tick();
    reset_ssn = 1'b1;
    a0 = n_ack; e0 = n_err; c0 = n_cs;
    reg_ack = 1'b1;
    tick();
    tick();
    tick();
    reg_ack = 1'b0;
    tick();
    tick();
    check("rw_nack",   n_ack - a0, 0);
    check("rw_nerr",   n_err - e0, 0);
    check("rw_ncs",    n_cs - c0, 0);

    check("ack_err_both", n_both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
